// File: rtl/snake_pkg.sv
// Shared encodings for the snake renderer: directions, scheduler states,
// palette and screen geometry.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ERASE,
    ST_SHIFT,
    ST_DRAW_HEAD,
    ST_DRAW_APPLE,
    ST_DONE
  } state_e;

  localparam logic [2:0] COL_SNAKE = 3'b010;
  localparam logic [2:0] COL_APPLE = 3'b100;
  localparam logic [2:0] COL_BG    = 3'b000;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // The encoding makes the reverse direction the bitwise complement.
  function automatic dir_e opposite(dir_e d);
    return dir_e'(~d);
  endfunction

endpackage

// File: rtl/snake_render_scheduler_if.sv
// Game-control and pixel-port bundle between the game top level (master)
// and the render scheduler (slave).
interface snake_render_scheduler_if #(
  parameter int MAXLEN = 8
);
  localparam int LEN_W = $clog2(MAXLEN + 1);

  logic             tick;
  logic [1:0]       dir;
  logic             grow;
  logic             apple_valid;
  logic [7:0]       apple_x;
  logic [6:0]       apple_y;

  logic             plot;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [2:0]       vga_colour;
  logic             busy;
  logic             done;
  logic [7:0]       head_x;
  logic [6:0]       head_y;
  logic [LEN_W-1:0] length;

  modport master (
    output tick, dir, grow, apple_valid, apple_x, apple_y,
    input  plot, vga_x, vga_y, vga_colour, busy, done, head_x, head_y, length
  );

  modport slave (
    input  tick, dir, grow, apple_valid, apple_x, apple_y,
    output plot, vga_x, vga_y, vga_colour, busy, done, head_x, head_y, length
  );

endinterface

// File: rtl/snake_render_scheduler_block_raster.sv
// Walks one XDIM x YDIM block a pixel per cycle, x inner and y outer.
// start opens a pass; the counters return to zero after the last pixel.
module block_raster #(
  parameter int XDIM = 10,
  parameter int YDIM = 10
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       start,
  input  logic [7:0] bx,
  input  logic [6:0] by,
  output logic [7:0] px,
  output logic [6:0] py,
  output logic       active,
  output logic       last
);
  localparam int XW = $clog2(XDIM);
  localparam int YW = $clog2(YDIM);

  logic [XW-1:0] r_xc;
  logic [YW-1:0] r_yc;
  logic          r_run;
  logic          w_x_end;
  logic          w_y_end;

  assign w_x_end = (r_xc == XW'(XDIM - 1));
  assign w_y_end = (r_yc == YW'(YDIM - 1));
  assign active  = start | r_run;
  assign last    = active & w_x_end & w_y_end;
  assign px      = bx + 8'(r_xc);
  assign py      = by + 7'(r_yc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_run <= 1'b0;
      r_xc  <= '0;
      r_yc  <= '0;
    end else if (active) begin
      r_run <= !last;
      if (w_x_end) begin
        r_xc <= '0;
        r_yc <= w_y_end ? '0 : r_yc + YW'(1);
      end else begin
        r_xc <= r_xc + XW'(1);
      end
    end
  end

endmodule

// File: rtl/snake_render_scheduler.sv
// Owns the snake segment buffer and sequences every pixel write per move:
// erase tail, shift in new head, draw head, optionally redraw the apple.
module snake_render_scheduler
  import snake_pkg::*;
#(
  parameter int         XDIM      = 10,
  parameter int         YDIM      = 10,
  parameter int         MAXLEN    = 8,
  parameter logic [7:0] X0        = 8'd39,
  parameter logic [6:0] Y0        = 7'd59,
  parameter int         XSCREEN   = SCREEN_W,
  parameter int         YSCREEN   = SCREEN_H,
  parameter logic [2:0] SNAKE_COL = COL_SNAKE,
  parameter logic [2:0] APPLE_COL = COL_APPLE,
  parameter logic [2:0] BG_COL    = COL_BG
) (
  input logic                     CLOCK_50,
  input logic                     Resetn,
  snake_render_scheduler_if.slave bus
);
  localparam int LEN_W = $clog2(MAXLEN + 1);
  localparam int IDX_W = $clog2(MAXLEN - 1);

  state_e           r_state, w_next_state;
  logic             r_entry;
  dir_e             r_cur_dir;
  logic             r_grow;
  logic             r_apple_valid;
  logic [7:0]       r_apple_x;
  logic [6:0]       r_apple_y;
  logic [7:0]       r_head_x;
  logic [6:0]       r_head_y;
  logic [7:0]       r_body_x [MAXLEN-1];
  logic [6:0]       r_body_y [MAXLEN-1];
  logic [LEN_W-1:0] r_length;

  logic             r_plot, r_busy, r_done;
  logic [7:0]       r_vga_x;
  logic [6:0]       r_vga_y;
  logic [2:0]       r_vga_colour;

  logic             w_can_grow;
  logic [IDX_W-1:0] w_body_idx;
  logic [7:0]       w_tail_x, w_new_x, w_bx, w_px;
  logic [6:0]       w_tail_y, w_new_y, w_by, w_py;
  logic [2:0]       w_colour;
  logic             w_draw, w_start, w_active, w_last;

  assign w_can_grow = bus.grow && (r_length < LEN_W'(MAXLEN));
  assign w_body_idx = IDX_W'(r_length - LEN_W'(2));
  assign w_tail_x   = (r_length == LEN_W'(1)) ? r_head_x : r_body_x[w_body_idx];
  assign w_tail_y   = (r_length == LEN_W'(1)) ? r_head_y : r_body_y[w_body_idx];
  assign w_start    = w_draw & r_entry;

  // Wrap is compared explicitly so a step never relies on adder overflow.
  always_comb begin
    w_new_x = r_head_x;
    w_new_y = r_head_y;
    case (r_cur_dir)
      DIR_RIGHT: w_new_x = (r_head_x >= 8'(XSCREEN - XDIM)) ? 8'd0 : r_head_x + 8'(XDIM);
      DIR_LEFT:  w_new_x = (r_head_x < 8'(XDIM)) ? 8'(XSCREEN - XDIM) : r_head_x - 8'(XDIM);
      DIR_DOWN:  w_new_y = (r_head_y >= 7'(YSCREEN - YDIM)) ? 7'd0 : r_head_y + 7'(YDIM);
      DIR_UP:    w_new_y = (r_head_y < 7'(YDIM)) ? 7'(YSCREEN - YDIM) : r_head_y - 7'(YDIM);
      default:   ;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    w_draw   = 1'b0;
    w_bx     = r_head_x;
    w_by     = r_head_y;
    w_colour = SNAKE_COL;
    case (r_state)
      ST_INIT, ST_DRAW_HEAD: w_draw = 1'b1;
      ST_ERASE: begin
        w_draw   = 1'b1;
        w_bx     = w_tail_x;
        w_by     = w_tail_y;
        w_colour = BG_COL;
      end
      ST_DRAW_APPLE: begin
        w_draw   = 1'b1;
        w_bx     = r_apple_x;
        w_by     = r_apple_y;
        w_colour = APPLE_COL;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT:       if (w_last) w_next_state = ST_IDLE;
      ST_IDLE:       if (bus.tick) w_next_state = w_can_grow ? ST_SHIFT : ST_ERASE;
      ST_ERASE:      if (w_last) w_next_state = ST_SHIFT;
      ST_SHIFT:      w_next_state = ST_DRAW_HEAD;
      ST_DRAW_HEAD:  if (w_last) w_next_state = r_apple_valid ? ST_DRAW_APPLE : ST_DONE;
      ST_DRAW_APPLE: if (w_last) w_next_state = ST_DONE;
      ST_DONE:       w_next_state = ST_IDLE;
      default:       w_next_state = ST_IDLE;
    endcase
  end

  block_raster #(.XDIM(XDIM), .YDIM(YDIM)) u_raster (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .start    (w_start),
    .bx       (w_bx),
    .by       (w_by),
    .px       (w_px),
    .py       (w_py),
    .active   (w_active),
    .last     (w_last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_state       <= ST_INIT;
      r_entry       <= 1'b1;
      r_cur_dir     <= DIR_RIGHT;
      r_grow        <= 1'b0;
      r_apple_valid <= 1'b0;
      r_apple_x     <= '0;
      r_apple_y     <= '0;
      r_head_x      <= X0;
      r_head_y      <= Y0;
      r_length      <= LEN_W'(1);
      r_plot        <= 1'b0;
      r_vga_x       <= '0;
      r_vga_y       <= '0;
      r_vga_colour  <= BG_COL;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_entry <= (w_next_state != r_state);
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= (r_state == ST_DONE);
      r_plot  <= w_active;
      if (w_active) begin
        r_vga_x      <= w_px;
        r_vga_y      <= w_py;
        r_vga_colour <= w_colour;
      end
      if (r_state == ST_IDLE && bus.tick) begin
        r_grow        <= w_can_grow;
        r_apple_valid <= bus.apple_valid;
        r_apple_x     <= bus.apple_x;
        r_apple_y     <= bus.apple_y;
        if (!(r_length > LEN_W'(1) && dir_e'(bus.dir) == opposite(r_cur_dir)))
          r_cur_dir <= dir_e'(bus.dir);
      end
      if (r_state == ST_SHIFT) begin
        r_head_x <= w_new_x;
        r_head_y <= w_new_y;
        if (r_grow) r_length <= r_length + LEN_W'(1);
      end
    end
  end

  // NOTE: body segments carry no reset; r_length decides which entries are
  // live, so stale contents beyond the tail are never read.
  always_ff @(posedge CLOCK_50) begin
    if (Resetn && r_state == ST_SHIFT) begin
      r_body_x[0] <= r_head_x;
      r_body_y[0] <= r_head_y;
      for (int i = 1; i < MAXLEN - 1; i++) begin
        r_body_x[i] <= r_body_x[i-1];
        r_body_y[i] <= r_body_y[i-1];
      end
    end
  end

  assign bus.plot       = r_plot;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.head_x     = r_head_x;
  assign bus.head_y     = r_head_y;
  assign bus.length     = r_length;

endmodule
